// File: rtl/sdram_port_arbiter_if.sv
// sdram_port_arbiter_if
// Requester-side bundle between the per-master Wishbone bridges and the
// SDRAM port arbiter. All vectors are packed per port: port k owns
// acc_i[k], we_i[k], adr_i[32k+31:32k], dat_i[16k+15:16k] and sel_i[2k+1:2k].
//   acc_i, we_i, adr_i, dat_i, sel_i : requester -> arbiter
//   ack_o                            : per-port ack (write accepted / read word valid)
//   dat_o, adr_o                     : read data and word address, broadcast
//   grant_o                          : one-hot current owner
// Modports: master (requester side / bench), slave (arbiter side).
interface sdram_port_arbiter_if #(
    parameter int NUM_PORTS = 2
);
    logic [NUM_PORTS-1:0]    acc_i;
    logic [NUM_PORTS-1:0]    we_i;
    logic [32*NUM_PORTS-1:0] adr_i;
    logic [16*NUM_PORTS-1:0] dat_i;
    logic [2*NUM_PORTS-1:0]  sel_i;
    logic [NUM_PORTS-1:0]    ack_o;
    logic [15:0]             dat_o;
    logic [31:0]             adr_o;
    logic [NUM_PORTS-1:0]    grant_o;

    modport master (
        output acc_i, we_i, adr_i, dat_i, sel_i,
        input  ack_o, dat_o, adr_o, grant_o
    );

    modport slave (
        input  acc_i, we_i, adr_i, dat_i, sel_i,
        output ack_o, dat_o, adr_o, grant_o
    );
endinterface

// File: rtl/sdram_port_arbiter.sv
// sdram_port_arbiter
// Shares the single access port of the SDRAM controller between NUM_PORTS
// requesters in the sdram_clk domain. Ownership is granted round-robin, kept
// across back-to-back accesses and read bursts, and handed over only once the
// controller is idle. An owner that has consumed MAX_HOLD acks while another
// port waits is forced to release.
// Ports:
//   sdram_clk, sdram_rst : clock, synchronous active-high reset
//   bus (slave)          : per-port requests, acks, grant, broadcast read data
//   ctrl_idle_i          : controller in idle / refresh / precharge-all
//   ctrl_acc_o, ctrl_we_o, ctrl_adr_o, ctrl_dat_o, ctrl_sel_o : to controller
//   ctrl_ack_i, ctrl_adr_i, ctrl_dat_i                        : from controller
// Build option: define SDRAM_ARB_FIXED_PRIO_EN for lowest-index-wins
// arbitration (rr_ptr held at 0); forced release still applies.
module sdram_port_arbiter #(
    parameter int NUM_PORTS = 2,
    parameter int MAX_HOLD  = 16
) (
    input  logic                sdram_clk,
    input  logic                sdram_rst,
    sdram_port_arbiter_if.slave bus,
    input  logic                ctrl_idle_i,
    output logic                ctrl_acc_o,
    output logic                ctrl_we_o,
    output logic [31:0]         ctrl_adr_o,
    output logic [15:0]         ctrl_dat_o,
    output logic [1:0]          ctrl_sel_o,
    input  logic                ctrl_ack_i,
    input  logic [31:0]         ctrl_adr_i,
    input  logic [15:0]         ctrl_dat_i
);
    localparam int          PW = (NUM_PORTS > 2) ? 2 : 1;
    localparam int unsigned NP = NUM_PORTS;

    typedef enum logic [1:0] {
        ARB   = 2'd0,
        OWN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t               state, state_nxt;
    logic [PW-1:0]        owner, owner_nxt;
    logic [PW-1:0]        rr_ptr, rr_ptr_nxt;
    logic [7:0]           hold_cnt, hold_cnt_nxt;

    logic [PW-1:0]        winner;
    logic                 win_valid;
    logic [NUM_PORTS-1:0] owner_oh;
    logic                 owner_req;
    logic                 others_req;
    logic [PW-1:0]        sel_port;
    int unsigned          idx;

    assign owner_oh   = {{(NUM_PORTS-1){1'b0}}, 1'b1} << owner;
    assign owner_req  = bus.acc_i[owner];
    assign others_req = |(bus.acc_i & ~owner_oh);

    // Winner search: first requester at or cyclically after rr_ptr
    // (rr_ptr is pinned to 0 in fixed-priority builds).
    always_comb begin
        winner    = '0;
        win_valid = 1'b0;
        idx       = 0;
        for (int unsigned i = 0; i < NP; i++) begin
`ifdef SDRAM_ARB_FIXED_PRIO_EN
            idx = i;
`else
            idx = (32'(rr_ptr) + i) % NP;
`endif
            if (!win_valid && bus.acc_i[idx]) begin
                winner    = PW'(idx);
                win_valid = 1'b1;
            end
        end
    end

    // State register
    always_ff @(posedge sdram_clk) begin
        if (sdram_rst) begin
            state    <= ARB;
            owner    <= '0;
            rr_ptr   <= '0;
            hold_cnt <= '0;
        end else begin
            state    <= state_nxt;
            owner    <= owner_nxt;
            rr_ptr   <= rr_ptr_nxt;
            hold_cnt <= hold_cnt_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt    = state;
        owner_nxt    = owner;
        rr_ptr_nxt   = rr_ptr;
        hold_cnt_nxt = hold_cnt;
        case (state)
            ARB: begin
                if (win_valid) begin
                    state_nxt    = OWN;
                    owner_nxt    = winner;
                    hold_cnt_nxt = '0;
                end
            end
            OWN: begin
                if (ctrl_ack_i && hold_cnt != 8'hFF)
                    hold_cnt_nxt = hold_cnt + 8'd1;
                // A drop and a forced release in the same cycle end up in
                // the same place, so one condition covers both.
                if (!owner_req || (hold_cnt >= 8'(MAX_HOLD) && others_req))
                    state_nxt = DRAIN;
            end
            DRAIN: begin
                // Wait out any accepted access (read-burst tail) before
                // letting the next owner in.
                if (ctrl_idle_i && !ctrl_ack_i) begin
                    state_nxt = ARB;
`ifdef SDRAM_ARB_FIXED_PRIO_EN
                    rr_ptr_nxt = '0;
`else
                    rr_ptr_nxt = (owner == PW'(NUM_PORTS - 1)) ? '0 : owner + 1'b1;
`endif
                end
            end
            default: state_nxt = ARB;
        endcase
    end

    // Outputs: the controller-side data mux follows port 0 while arbitrating
    // and is forced to zero during reset.
    always_comb begin
        sel_port    = (state == ARB) ? '0 : owner;
        ctrl_acc_o  = 1'b0;
        ctrl_we_o   = 1'b0;
        ctrl_adr_o  = '0;
        ctrl_dat_o  = '0;
        ctrl_sel_o  = '0;
        if (!sdram_rst) begin
            ctrl_acc_o = (state == OWN) && owner_req;
            ctrl_we_o  = bus.we_i[sel_port];
            ctrl_adr_o = bus.adr_i[32*sel_port +: 32];
            ctrl_dat_o = bus.dat_i[16*sel_port +: 16];
            ctrl_sel_o = bus.sel_i[2*sel_port +: 2];
        end
        bus.grant_o = (state != ARB) ? owner_oh : '0;
        bus.ack_o   = (state != ARB && ctrl_ack_i) ? owner_oh : '0;
        bus.dat_o   = ctrl_dat_i;
        bus.adr_o   = ctrl_adr_i;
    end
endmodule

// File: tb/tb_sdram_port_arbiter.sv
// tb_sdram_port_arbiter
// Self-checking bench for sdram_port_arbiter with two ports and MAX_HOLD=4.
// A small controller model answers writes with one ack and reads with an
// 8-word burst, then stays busy for 1+mc_extra cycles. Expected acks are
// queued per port when a request is driven and checked as acks arrive.
module tb_sdram_port_arbiter;
    localparam int NP   = 2;
    localparam int HOLD = 4;
`ifdef SDRAM_ARB_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sdram_port_arbiter_if #(.NUM_PORTS(NP)) bus ();

    logic        ctrl_idle_i, ctrl_acc_o, ctrl_we_o, ctrl_ack_i;
    logic [31:0] ctrl_adr_o, ctrl_adr_i;
    logic [15:0] ctrl_dat_o, ctrl_dat_i;
    logic [1:0]  ctrl_sel_o;

    sdram_port_arbiter #(.NUM_PORTS(NP), .MAX_HOLD(HOLD)) dut (
        .sdram_clk  (clk),
        .sdram_rst  (rst),
        .bus        (bus),
        .ctrl_idle_i(ctrl_idle_i),
        .ctrl_acc_o (ctrl_acc_o),
        .ctrl_we_o  (ctrl_we_o),
        .ctrl_adr_o (ctrl_adr_o),
        .ctrl_dat_o (ctrl_dat_o),
        .ctrl_sel_o (ctrl_sel_o),
        .ctrl_ack_i (ctrl_ack_i),
        .ctrl_adr_i (ctrl_adr_i),
        .ctrl_dat_i (ctrl_dat_i)
    );

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] rd_word(input logic [31:0] a);
        return a[15:0] ^ 16'h5A5A;
    endfunction

    // ---------------- controller model ----------------
    int          mc_phase = 0;
    int          mc_left  = 0;
    int          mc_gap   = 0;
    int          mc_extra = 0;
    logic [31:0] mc_adr;
    logic        mc_we;
    logic [15:0] mc_wdat;

    assign ctrl_idle_i = (mc_phase == 0);

    always @(posedge clk) begin
        if (rst) begin
            mc_phase   <= 0;
            ctrl_ack_i <= 1'b0;
            ctrl_adr_i <= '0;
            ctrl_dat_i <= '0;
        end else begin
            case (mc_phase)
                0: begin
                    ctrl_ack_i <= 1'b0;
                    if (ctrl_acc_o) begin
                        mc_adr   <= ctrl_adr_o;
                        mc_we    <= ctrl_we_o;
                        mc_wdat  <= ctrl_dat_o;
                        mc_left  <= ctrl_we_o ? 1 : 8;
                        mc_phase <= 1;
                    end
                end
                1: begin
                    ctrl_ack_i <= 1'b1;
                    ctrl_adr_i <= mc_adr;
                    ctrl_dat_i <= mc_we ? mc_wdat : rd_word(mc_adr);
                    mc_adr     <= mc_adr + 32'd2;
                    mc_left    <= mc_left - 1;
                    if (mc_left == 1) begin
                        mc_phase <= 2;
                        mc_gap   <= 1 + mc_extra;
                    end
                end
                default: begin
                    ctrl_ack_i <= 1'b0;
                    if (mc_gap == 0) mc_phase <= 0;
                    else             mc_gap   <= mc_gap - 1;
                end
            endcase
        end
    end

    // ---------------- scoreboard ----------------
    typedef struct packed {
        logic [31:0] adr;
        logic [15:0] dat;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    task automatic push_exp(input int k, input logic [31:0] a, input logic [15:0] d);
        exp_t e;
        e.adr = a;
        e.dat = d;
        if (k == 0) q0.push_back(e);
        else        q1.push_back(e);
    endtask

    task automatic push_read(input int k, input logic [31:0] a);
        for (int i = 0; i < 8; i++)
            push_exp(k, a + 32'(2*i), rd_word(a + 32'(2*i)));
    endtask

    always @(negedge clk) begin
        if (!rst && bus.ack_o != '0) begin
            check_eq("ack_onehot", 64'($countones(bus.ack_o)), 1);
            for (int k = 0; k < NP; k++) begin
                if (bus.ack_o[k]) begin
                    exp_t e;
                    check_eq($sformatf("ack%0d_granted", k), bus.grant_o[k], 1);
                    if ((k == 0 && q0.size() == 0) || (k == 1 && q1.size() == 0)) begin
                        check_eq($sformatf("ack%0d_unexpected", k), bus.ack_o[k], 0);
                    end else begin
                        e = (k == 0) ? q0.pop_front() : q1.pop_front();
                        check_eq($sformatf("ack%0d_adr", k), bus.adr_o, e.adr);
                        check_eq($sformatf("ack%0d_dat", k), bus.dat_o, e.dat);
                    end
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int k, input logic a, input logic w,
                         input logic [31:0] ad, input logic [15:0] d);
        bus.acc_i[k]          = a;
        bus.we_i[k]           = w;
        bus.adr_i[32*k +: 32] = ad;
        bus.dat_i[16*k +: 16] = d;
        bus.sel_i[2*k +: 2]   = 2'b11;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.acc_i = '0;
        tick();
        tick();
        q0.delete();
        q1.delete();
        rst = 1'b0;
    endtask

    function automatic int oh_idx(input logic [NP-1:0] v);
        for (int i = 0; i < NP; i++)
            if (v[i]) return i;
        return -1;
    endfunction

    int gorder[$];

    // Serve all pending requests: each requester drops acc on its first ack.
    task automatic serve_all(input string tag);
        logic [NP-1:0] prev;
        prev = '0;
        gorder.delete();
        for (int cyc = 0; cyc < 600; cyc++) begin
            tick();
            if (bus.grant_o != '0 && bus.grant_o != prev)
                gorder.push_back(oh_idx(bus.grant_o));
            prev = bus.grant_o;
            for (int k = 0; k < NP; k++)
                if (bus.acc_i[k] && bus.ack_o[k]) bus.acc_i[k] = 1'b0;
            if (bus.acc_i == '0 && bus.grant_o == '0 && q0.size() == 0 && q1.size() == 0)
                return;
        end
        check_eq({tag, "_timeout"}, {32'(q0.size() + q1.size()), 28'd0, bus.acc_i, bus.grant_o}, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1);
    end

    // ---------------- scenarios ----------------
    initial begin
        int  w0;
        int  drain;
        bit  seen;
        bit  saw_forced;

        bus.acc_i = '0;
        bus.we_i  = '0;
        bus.adr_i = '0;
        bus.dat_i = '0;
        bus.sel_i = '0;

        // Reset values, with port 0 presenting a non-zero write
        rst = 1'b1;
        drive(0, 1'b0, 1'b1, 32'hDEAD_BEEF, 16'h1234);
        tick();
        tick();
        check_eq("rst_grant",    bus.grant_o, 0);
        check_eq("rst_ack",      bus.ack_o,   0);
        check_eq("rst_ctrl_acc", ctrl_acc_o,  0);
        check_eq("rst_ctrl_we",  ctrl_we_o,   0);
        check_eq("rst_ctrl_adr", ctrl_adr_o,  0);
        check_eq("rst_ctrl_dat", ctrl_dat_o,  0);
        check_eq("rst_ctrl_sel", ctrl_sel_o,  0);
        rst = 1'b0;
        #1;
        check_eq("arb_mux_port0", ctrl_adr_o, 32'hDEAD_BEEF);
        check_eq("arb_acc_low",   ctrl_acc_o, 0);

        // Single port read burst from port 1
        drive(1, 1'b1, 1'b0, 32'h100, 16'h0);
        push_read(1, 32'h100);
        tick();
        check_eq("s1_grant",    bus.grant_o, 2'b10);
        check_eq("s1_ctrl_acc", ctrl_acc_o,  1);
        check_eq("s1_ctrl_adr", ctrl_adr_o,  32'h100);
        serve_all("s1");
        check_eq("s1_rr_ptr", dut.rr_ptr, 0);

        // Simultaneous requests right after reset
        do_reset();
        drive(0, 1'b1, 1'b0, 32'h200, 16'h0);
        drive(1, 1'b1, 1'b0, 32'h300, 16'h0);
        push_read(0, 32'h200);
        push_read(1, 32'h300);
        tick();
        check_eq("s2_first_grant", bus.grant_o, 2'b01);
        serve_all("s2");
        check_eq("s2_tenures", gorder.size(), 2);
        if (gorder.size() == 2) begin
            check_eq("s2_order0", gorder[0], 0);
            check_eq("s2_order1", gorder[1], 1);
        end

        // Forced release: port 0 streams 6 writes, port 1 joins after the first
        do_reset();
        drive(0, 1'b1, 1'b1, 32'h400, 16'h1000);
        push_exp(0, 32'h400, 16'h1000);
        w0 = 0;
        seen = 1'b0;
        saw_forced = 1'b0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            tick();
            if (bus.grant_o == 2'b01 && bus.acc_i[0] && !ctrl_acc_o) saw_forced = 1'b1;
            if (bus.grant_o == 2'b10 && !seen) begin
                seen = 1'b1;
                check_eq("s3_acks_before_p1", w0, FIXED ? 6 : HOLD);
            end
            if (bus.ack_o[0] && bus.acc_i[0]) begin
                w0++;
                if (w0 < 6) begin
                    drive(0, 1'b1, 1'b1, 32'h400 + 32'(2*w0), 16'h1000 + 16'(w0));
                    push_exp(0, 32'h400 + 32'(2*w0), 16'h1000 + 16'(w0));
                end else begin
                    bus.acc_i[0] = 1'b0;
                end
                if (w0 == 1) begin
                    drive(1, 1'b1, 1'b0, 32'h500, 16'h0);
                    push_read(1, 32'h500);
                end
            end
            if (bus.ack_o[1] && bus.acc_i[1]) bus.acc_i[1] = 1'b0;
            if (bus.acc_i == '0 && bus.grant_o == '0 && q0.size() == 0 && q1.size() == 0) break;
        end
        check_eq("s3_p1_granted",  seen, 1);
        check_eq("s3_forced_drop", saw_forced, 1);
        check_eq("s3_p0_writes",   w0, 6);
        check_eq("s3_drained",     32'(q0.size() + q1.size()), 0);

        // Read tail in DRAIN with a controller that stays busy afterwards
        do_reset();
        mc_extra = 3;
        drive(0, 1'b1, 1'b0, 32'h600, 16'h0);
        drive(1, 1'b1, 1'b0, 32'h700, 16'h0);
        push_read(0, 32'h600);
        push_read(1, 32'h700);
        tick();
        check_eq("s4_first_grant", bus.grant_o, 2'b01);
        drain = 0;
        seen = 1'b0;
        for (int cyc = 0; cyc < 200; cyc++) begin
            tick();
            if (bus.grant_o == 2'b01 && !bus.acc_i[0]) drain++;
            if (bus.grant_o == 2'b10) begin
                seen = 1'b1;
                check_eq("s4_tail_done",    q0.size(), 0);
                check_eq("s4_drain_cycles", drain, 9 + 3);
                break;
            end
            if (bus.ack_o[0] && bus.acc_i[0]) bus.acc_i[0] = 1'b0;
        end
        check_eq("s4_p1_granted", seen, 1);
        serve_all("s4");
        mc_extra = 0;

        // Reset in the middle of a read burst
        do_reset();
        drive(0, 1'b1, 1'b0, 32'h800, 16'h0);
        push_read(0, 32'h800);
        w0 = 0;
        for (int cyc = 0; cyc < 100 && w0 < 3; cyc++) begin
            tick();
            if (bus.ack_o[0]) w0++;
        end
        check_eq("s5_acks_seen", w0, 3);
        rst = 1'b1;
        bus.acc_i = '0;
        #1;
        check_eq("s5_rst_ctrl_acc", ctrl_acc_o, 0);
        check_eq("s5_rst_ctrl_adr", ctrl_adr_o, 0);
        tick();
        rst = 1'b0;
        q0.delete();
        q1.delete();
        #1;
        check_eq("s5_grant", bus.grant_o, 0);
        check_eq("s5_ctrl_acc", ctrl_acc_o, 0);
        check_eq("s5_ack", bus.ack_o, 0);
        drive(1, 1'b1, 1'b1, 32'h880, 16'hBEEF);
        push_exp(1, 32'h880, 16'hBEEF);
        serve_all("s5_recover");

        // Pointer advance: after a port 0 tenure a tie goes to port 1
        do_reset();
        drive(0, 1'b1, 1'b1, 32'h900, 16'h2222);
        push_exp(0, 32'h900, 16'h2222);
        serve_all("s6a");
        drive(0, 1'b1, 1'b0, 32'hA00, 16'h0);
        drive(1, 1'b1, 1'b0, 32'hB00, 16'h0);
        push_read(0, 32'hA00);
        push_read(1, 32'hB00);
        tick();
        check_eq("s6_first_grant", bus.grant_o, FIXED ? 2'b01 : 2'b10);
        serve_all("s6b");
        check_eq("s6_tenures", gorder.size(), 2);
        if (gorder.size() == 2) begin
            check_eq("s6_order0", gorder[0], FIXED ? 0 : 1);
            check_eq("s6_order1", gorder[1], FIXED ? 1 : 0);
        end

        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
